// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end types: branch-prediction metadata carried from fetch to resolve.
package rv32i_pkg;

    localparam int BPU_PC_W       = 32;
    localparam int BPU_FIFO_DEPTH = 4;

    typedef struct packed {
        logic [BPU_PC_W-1:0] pc;
        logic [BPU_PC_W-1:0] next_pc;
        logic                hit;
        logic                taken;
        logic                glb_taken;
        logic                loc_taken;
    } BpuPredMeta_s;

endpackage

// File: rtl/bpu_resolve_if.sv
// Fetch/resolve bus of the branch resolve unit; master is the pipeline, slave is bpu_resolve.
interface bpu_resolve_if #(
    parameter int PC_WIDTH   = 32,
    parameter int PERF_CNT_W = 32
);
    logic                  i_pred_vld;
    logic                  o_pred_rdy;
    logic [PC_WIDTH-1:0]   i_pred_pc;
    logic [PC_WIDTH-1:0]   i_pred_next_pc;
    logic                  i_pred_hit;
    logic                  i_pred_taken;
    logic                  i_pred_glb_taken;
    logic                  i_pred_loc_taken;
    logic                  i_res_vld;
    logic                  i_res_is_br;
    logic                  i_res_is_jmp;
    logic                  i_res_taken;
    logic [PC_WIDTH-1:0]   i_res_target;
    logic                  i_flush;
    logic                  o_redirect;
    logic [PC_WIDTH-1:0]   o_redirect_pc;
    logic                  o_upd_btb_vld;
    logic [PC_WIDTH-1:0]   o_upd_btb_pc;
    logic [PC_WIDTH-1:0]   o_upd_btb_br_addr;
    logic                  o_upd_pht_vld;
    logic                  o_upd_eval_vld;
    logic [PC_WIDTH-1:0]   o_upd_pht_pc;
    logic                  o_upd_pht_taken;
    logic                  o_upd_pht_pred_glb_taken;
    logic                  o_upd_pht_pred_loc_taken;
    logic                  o_err;
    logic [PERF_CNT_W-1:0] o_perf_br_cnt;
    logic [PERF_CNT_W-1:0] o_perf_mispred_cnt;

    modport master (
        output i_pred_vld, i_pred_pc, i_pred_next_pc, i_pred_hit, i_pred_taken,
               i_pred_glb_taken, i_pred_loc_taken, i_res_vld, i_res_is_br,
               i_res_is_jmp, i_res_taken, i_res_target, i_flush,
        input  o_pred_rdy, o_redirect, o_redirect_pc, o_upd_btb_vld, o_upd_btb_pc,
               o_upd_btb_br_addr, o_upd_pht_vld, o_upd_eval_vld, o_upd_pht_pc,
               o_upd_pht_taken, o_upd_pht_pred_glb_taken, o_upd_pht_pred_loc_taken,
               o_err, o_perf_br_cnt, o_perf_mispred_cnt
    );

    modport slave (
        input  i_pred_vld, i_pred_pc, i_pred_next_pc, i_pred_hit, i_pred_taken,
               i_pred_glb_taken, i_pred_loc_taken, i_res_vld, i_res_is_br,
               i_res_is_jmp, i_res_taken, i_res_target, i_flush,
        output o_pred_rdy, o_redirect, o_redirect_pc, o_upd_btb_vld, o_upd_btb_pc,
               o_upd_btb_br_addr, o_upd_pht_vld, o_upd_eval_vld, o_upd_pht_pc,
               o_upd_pht_taken, o_upd_pht_pred_glb_taken, o_upd_pht_pred_loc_taken,
               o_err, o_perf_br_cnt, o_perf_mispred_cnt
    );
endinterface

// File: rtl/bpu_meta_fifo.sv
// In-order FIFO of in-flight prediction metadata; wrap-bit pointers, clear dominates push/pop.
module bpu_meta_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_full,
    output logic              o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_do_push;
    logic              w_do_pop;

    assign w_do_push = i_push & ~o_full & ~i_clear;
    assign w_do_pop  = i_pop & ~o_empty & ~i_clear;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_clear) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

    // Equal index with differing wrap bit means the writer lapped the reader.
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_rdata = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/bpu_resolve.sv
// Branch resolve unit: matches resolutions to queued predictions, emits predictor updates and redirects.
// Optional build macro BPU_PERF_CNT_EN enables saturating branch / mispredict counters.
module bpu_resolve
    import rv32i_pkg::*;
#(
    parameter int PC_WIDTH   = BPU_PC_W,
    parameter int FIFO_DEPTH = BPU_FIFO_DEPTH,
    parameter int PERF_CNT_W = 32
) (
    input logic          i_clk,
    input logic          i_rst_n,
    bpu_resolve_if.slave io_bpu
);
    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [PC_WIDTH-1:0] next_pc;
        logic                hit;
        logic                taken;
        logic                glb_taken;
        logic                loc_taken;
    } meta_t;

    localparam int META_W = $bits(meta_t);

    meta_t               w_wmeta;
    meta_t               w_head;
    logic [META_W-1:0]   w_head_bits;
    logic                w_full, w_empty, w_rdy, w_push, w_clear;
    logic                w_res_ok, w_underflow, w_mispred, w_is_cti;
    logic                w_pht, w_eval, w_btb, w_unused;
    logic [PC_WIDTH-1:0] w_actual;
    logic                r_live;
    logic                r_redirect, r_btb_vld, r_pht_vld, r_eval_vld, r_err;
    logic                r_pht_taken, r_pht_glb, r_pht_loc;
    logic [PC_WIDTH-1:0] r_redirect_pc, r_btb_pc, r_btb_addr, r_pht_pc;

    assign w_wmeta.pc        = io_bpu.i_pred_pc;
    assign w_wmeta.next_pc   = io_bpu.i_pred_next_pc;
    assign w_wmeta.hit       = io_bpu.i_pred_hit;
    assign w_wmeta.taken     = io_bpu.i_pred_taken;
    assign w_wmeta.glb_taken = io_bpu.i_pred_glb_taken;
    assign w_wmeta.loc_taken = io_bpu.i_pred_loc_taken;
    assign w_head            = w_head_bits;
    assign w_unused          = w_head.taken;

    // Resolution sees only the head present at cycle start; flush overrides everything.
    assign w_res_ok    = io_bpu.i_res_vld & ~w_empty & ~io_bpu.i_flush;
    assign w_underflow = io_bpu.i_res_vld & w_empty & ~io_bpu.i_flush;
    assign w_actual    = io_bpu.i_res_taken ? io_bpu.i_res_target : w_head.pc + PC_WIDTH'(4);
    assign w_mispred   = w_res_ok & (w_actual != w_head.next_pc);
    assign w_clear     = io_bpu.i_flush | w_mispred;
    assign w_rdy       = r_live & ~w_full;
    assign w_push      = io_bpu.i_pred_vld & w_rdy & ~w_clear;
    assign w_is_cti    = io_bpu.i_res_is_br | io_bpu.i_res_is_jmp;
    assign w_pht       = w_res_ok & io_bpu.i_res_is_br;
    assign w_eval      = w_pht & w_head.hit;
    assign w_btb       = w_res_ok & w_is_cti & io_bpu.i_res_taken & (~w_head.hit | w_mispred);

    bpu_meta_fifo #(
        .DATA_W (META_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_pop   (w_res_ok),
        .i_clear (w_clear),
        .i_wdata (w_wmeta),
        .o_rdata (w_head_bits),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_live        <= 1'b0;
            r_redirect    <= 1'b0;
            r_btb_vld     <= 1'b0;
            r_pht_vld     <= 1'b0;
            r_eval_vld    <= 1'b0;
            r_err         <= 1'b0;
            r_pht_taken   <= 1'b0;
            r_pht_glb     <= 1'b0;
            r_pht_loc     <= 1'b0;
            r_redirect_pc <= '0;
            r_btb_pc      <= '0;
            r_btb_addr    <= '0;
            r_pht_pc      <= '0;
        end else begin
            r_live     <= 1'b1;
            r_redirect <= w_mispred;
            r_btb_vld  <= w_btb;
            r_pht_vld  <= w_pht;
            r_eval_vld <= w_eval;
            if (w_underflow) r_err <= 1'b1;
            if (w_mispred) r_redirect_pc <= w_actual;
            if (w_btb) begin
                r_btb_pc   <= w_head.pc;
                r_btb_addr <= io_bpu.i_res_target;
            end
            if (w_pht) begin
                r_pht_pc    <= w_head.pc;
                r_pht_taken <= io_bpu.i_res_taken;
                r_pht_glb   <= w_head.glb_taken;
                r_pht_loc   <= w_head.loc_taken;
            end
        end
    end

    assign io_bpu.o_pred_rdy               = w_rdy;
    assign io_bpu.o_redirect               = r_redirect;
    assign io_bpu.o_redirect_pc            = r_redirect_pc;
    assign io_bpu.o_upd_btb_vld            = r_btb_vld;
    assign io_bpu.o_upd_btb_pc             = r_btb_pc;
    assign io_bpu.o_upd_btb_br_addr        = r_btb_addr;
    assign io_bpu.o_upd_pht_vld            = r_pht_vld;
    assign io_bpu.o_upd_eval_vld           = r_eval_vld;
    assign io_bpu.o_upd_pht_pc             = r_pht_pc;
    assign io_bpu.o_upd_pht_taken          = r_pht_taken;
    assign io_bpu.o_upd_pht_pred_glb_taken = r_pht_glb;
    assign io_bpu.o_upd_pht_pred_loc_taken = r_pht_loc;
    assign io_bpu.o_err                    = r_err;

`ifdef BPU_PERF_CNT_EN
    localparam logic [PERF_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [PERF_CNT_W-1:0] CNT_ONE = PERF_CNT_W'(1);

    logic [PERF_CNT_W-1:0] r_br_cnt;
    logic [PERF_CNT_W-1:0] r_mis_cnt;

    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_br_cnt  <= '0;
            r_mis_cnt <= '0;
        end else begin
            if (w_res_ok && w_is_cti && (r_br_cnt != CNT_MAX)) r_br_cnt <= r_br_cnt + CNT_ONE;
            if (w_mispred && (r_mis_cnt != CNT_MAX)) r_mis_cnt <= r_mis_cnt + CNT_ONE;
        end
    end

    assign io_bpu.o_perf_br_cnt      = r_br_cnt;
    assign io_bpu.o_perf_mispred_cnt = r_mis_cnt;
`else
    assign io_bpu.o_perf_br_cnt      = {PERF_CNT_W{1'b0}};
    assign io_bpu.o_perf_mispred_cnt = {PERF_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_bpu_resolve.sv
// Self-checking bench for bpu_resolve: queue-based reference model checked every cycle plus directed literals.
module tb_bpu_resolve;
    import rv32i_pkg::*;

    localparam int DEPTH = 4;
    localparam int PW    = 4;
    localparam int CMAX  = (1 << PW) - 1;
`ifdef BPU_PERF_CNT_EN
    localparam int SAT_EXP = CMAX;
`else
    localparam int SAT_EXP = 0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    bpu_resolve_if #(.PC_WIDTH(32), .PERF_CNT_W(PW)) bus ();

    bpu_resolve #(
        .PC_WIDTH   (32),
        .FIFO_DEPTH (DEPTH),
        .PERF_CNT_W (PW)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bpu  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of predictions plus the expected registered outputs.
    BpuPredMeta_s mq[$];
    BpuPredMeta_s mh;
    logic [31:0]  mActual;
    bit           mMis, mCanPush, mLive;
    bit           expRedirect, expBtbVld, expPhtVld, expEvalVld, expErr;
    bit           expPhtTaken, expPhtGlb, expPhtLoc;
    logic [31:0]  expRedirectPc, expBtbPc, expBtbAddr, expPhtPc;
    int           expBrCnt, expMisCnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mLive = 0;
            expRedirect = 0; expBtbVld = 0; expPhtVld = 0; expEvalVld = 0; expErr = 0;
            expPhtTaken = 0; expPhtGlb = 0; expPhtLoc = 0;
            expRedirectPc = 0; expBtbPc = 0; expBtbAddr = 0; expPhtPc = 0;
            expBrCnt = 0; expMisCnt = 0;
        end else begin
            mCanPush = mLive && (mq.size() < DEPTH);
            mLive = 1;
            mMis = 0;
            expRedirect = 0; expBtbVld = 0; expPhtVld = 0; expEvalVld = 0;
            if (bus.i_flush) begin
                mq.delete();
            end else begin
                if (bus.i_res_vld) begin
                    if (mq.size() == 0) begin
                        expErr = 1;
                    end else begin
                        mh = mq.pop_front();
                        mActual = bus.i_res_taken ? bus.i_res_target : mh.pc + 32'd4;
                        mMis = (mActual != mh.next_pc);
                        if (bus.i_res_is_br) begin
                            expPhtVld = 1;
                            expEvalVld = mh.hit;
                            expPhtPc = mh.pc;
                            expPhtTaken = bus.i_res_taken;
                            expPhtGlb = mh.glb_taken;
                            expPhtLoc = mh.loc_taken;
                        end
                        if ((bus.i_res_is_br || bus.i_res_is_jmp) && bus.i_res_taken && (!mh.hit || mMis)) begin
                            expBtbVld = 1;
                            expBtbPc = mh.pc;
                            expBtbAddr = bus.i_res_target;
                        end
                        if ((bus.i_res_is_br || bus.i_res_is_jmp) && expBrCnt < CMAX) expBrCnt++;
                        if (mMis) begin
                            expRedirect = 1;
                            expRedirectPc = mActual;
                            if (expMisCnt < CMAX) expMisCnt++;
                            mq.delete();
                        end
                    end
                end
                if (bus.i_pred_vld && mCanPush && !mMis)
                    mq.push_back('{pc: bus.i_pred_pc, next_pc: bus.i_pred_next_pc, hit: bus.i_pred_hit,
                                   taken: bus.i_pred_taken, glb_taken: bus.i_pred_glb_taken,
                                   loc_taken: bus.i_pred_loc_taken});
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, away from the rising edge, compare all outputs against the model.
    always @(negedge clk) begin
        checkOutput("m_rdy", bus.o_pred_rdy, 64'(rst_n && mLive && (mq.size() < DEPTH)));
        checkOutput("m_redirect", bus.o_redirect, 64'(expRedirect));
        checkOutput("m_redirect_pc", bus.o_redirect_pc, 64'(expRedirectPc));
        checkOutput("m_btb_vld", bus.o_upd_btb_vld, 64'(expBtbVld));
        checkOutput("m_btb_pc", bus.o_upd_btb_pc, 64'(expBtbPc));
        checkOutput("m_btb_addr", bus.o_upd_btb_br_addr, 64'(expBtbAddr));
        checkOutput("m_pht_vld", bus.o_upd_pht_vld, 64'(expPhtVld));
        checkOutput("m_eval_vld", bus.o_upd_eval_vld, 64'(expEvalVld));
        checkOutput("m_pht_pc", bus.o_upd_pht_pc, 64'(expPhtPc));
        checkOutput("m_pht_taken", bus.o_upd_pht_taken, 64'(expPhtTaken));
        checkOutput("m_pht_glb", bus.o_upd_pht_pred_glb_taken, 64'(expPhtGlb));
        checkOutput("m_pht_loc", bus.o_upd_pht_pred_loc_taken, 64'(expPhtLoc));
        checkOutput("m_err", bus.o_err, 64'(expErr));
`ifdef BPU_PERF_CNT_EN
        checkOutput("m_br_cnt", bus.o_perf_br_cnt, 64'(expBrCnt));
        checkOutput("m_mis_cnt", bus.o_perf_mispred_cnt, 64'(expMisCnt));
`else
        checkOutput("m_br_cnt", bus.o_perf_br_cnt, 64'(0));
        checkOutput("m_mis_cnt", bus.o_perf_mispred_cnt, 64'(0));
`endif
    end

    // Drive one cycle of inputs, consume the rising edge, then return valids to idle.
    task automatic applyStimulus(input bit pv, input logic [31:0] pc, input logic [31:0] npc, input bit hit,
                                 input bit rv, input bit isBr, input bit isJmp, input bit rTaken,
                                 input logic [31:0] tgt, input bit fl);
        bus.i_pred_vld       = pv;
        bus.i_pred_pc        = pc;
        bus.i_pred_next_pc   = npc;
        bus.i_pred_hit       = hit;
        bus.i_pred_taken     = (npc != pc + 32'd4);
        bus.i_pred_glb_taken = pc[4];
        bus.i_pred_loc_taken = pc[5];
        bus.i_res_vld        = rv;
        bus.i_res_is_br      = isBr;
        bus.i_res_is_jmp     = isJmp;
        bus.i_res_taken      = rTaken;
        bus.i_res_target     = tgt;
        bus.i_flush          = fl;
        @(posedge clk);
        #1;
        bus.i_pred_vld = 0;
        bus.i_res_vld  = 0;
        bus.i_flush    = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.i_pred_vld = 0; bus.i_pred_pc = 0; bus.i_pred_next_pc = 0; bus.i_pred_hit = 0;
        bus.i_pred_taken = 0; bus.i_pred_glb_taken = 0; bus.i_pred_loc_taken = 0;
        bus.i_res_vld = 0; bus.i_res_is_br = 0; bus.i_res_is_jmp = 0; bus.i_res_taken = 0;
        bus.i_res_target = 0; bus.i_flush = 0;
        rst_n = 1;
        #1 rst_n = 0;
        @(negedge clk);
        checkOutput("rst_rdy", bus.o_pred_rdy, 0);
        checkOutput("rst_err", bus.o_err, 0);
        @(posedge clk); #2 rst_n = 1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("post_rst_rdy", bus.o_pred_rdy, 1);

        // Correct taken prediction with BTB hit: PHT and eval update only.
        applyStimulus(1, 32'h100, 32'h200, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 1, 32'h200, 0);
        @(negedge clk);
        checkOutput("s1_pht_vld", bus.o_upd_pht_vld, 1);
        checkOutput("s1_eval_vld", bus.o_upd_eval_vld, 1);
        checkOutput("s1_btb_vld", bus.o_upd_btb_vld, 0);
        checkOutput("s1_redirect", bus.o_redirect, 0);
        checkOutput("s1_pht_pc", bus.o_upd_pht_pc, 32'h100);
        @(negedge clk);
        checkOutput("s1_pulse_end", bus.o_upd_pht_vld, 0);

        // BTB miss, actually taken: redirect and BTB allocate.
        applyStimulus(1, 32'h100, 32'h104, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 1, 32'h180, 0);
        @(negedge clk);
        checkOutput("s2_redirect", bus.o_redirect, 1);
        checkOutput("s2_redirect_pc", bus.o_redirect_pc, 32'h180);
        checkOutput("s2_btb_vld", bus.o_upd_btb_vld, 1);
        checkOutput("s2_btb_addr", bus.o_upd_btb_br_addr, 32'h180);
        checkOutput("s2_btb_pc", bus.o_upd_btb_pc, 32'h100);
        checkOutput("s2_eval_vld", bus.o_upd_eval_vld, 0);

        // Fill to full, overflow push ignored, pop+push while full drops the push.
        for (int i = 1; i <= 4; i++)
            applyStimulus(1, 32'(i * 16), 32'(i * 16 + 4), 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("s3_full_rdy", bus.o_pred_rdy, 0);
        applyStimulus(1, 32'h500, 32'h504, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h5A0, 32'h5A4, 1, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("s3_rdy_after_pop", bus.o_pred_rdy, 1);
        checkOutput("s3_pht_pc_1", bus.o_upd_pht_pc, 32'h10);
        for (int i = 2; i <= 4; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
            @(negedge clk);
            checkOutput("s3_pht_pc_n", bus.o_upd_pht_pc, 32'(i * 16));
            checkOutput("s3_no_redirect", bus.o_redirect, 0);
        end
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("s3_underflow_err", bus.o_err, 1);
        checkOutput("s3_underflow_pht", bus.o_upd_pht_vld, 0);

        // Mispredict drops the same-cycle push; flush suppresses the resolve.
        applyStimulus(1, 32'h600, 32'h604, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h800, 32'h804, 1, 1, 1, 0, 1, 32'h700, 0);
        @(negedge clk);
        checkOutput("s4_redirect", bus.o_redirect, 1);
        checkOutput("s4_redirect_pc", bus.o_redirect_pc, 32'h700);
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("s4_push_dropped", bus.o_upd_pht_vld, 0);
        applyStimulus(1, 32'h900, 32'h904, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'hA00, 32'hA04, 1, 1, 1, 0, 1, 32'hB00, 1);
        @(negedge clk);
        checkOutput("s4_flush_pht", bus.o_upd_pht_vld, 0);
        checkOutput("s4_flush_redirect", bus.o_redirect, 0);
        checkOutput("s4_flush_btb", bus.o_upd_btb_vld, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("s4_flush_empty", bus.o_upd_pht_vld, 0);

        // Jumps, non-branch mispredict, and PC wrap on the fall-through path.
        applyStimulus(1, 32'hB00, 32'hC00, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 1, 1, 32'hC00, 0);
        @(negedge clk);
        checkOutput("s5_jmp_hit_btb", bus.o_upd_btb_vld, 0);
        checkOutput("s5_jmp_pht", bus.o_upd_pht_vld, 0);
        applyStimulus(1, 32'hD00, 32'hE00, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("s5_nonbr_redirect", bus.o_redirect, 1);
        checkOutput("s5_nonbr_pc", bus.o_redirect_pc, 32'hD04);
        applyStimulus(1, 32'hF00, 32'hF04, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 1, 1, 32'hF04, 0);
        @(negedge clk);
        checkOutput("s5_jmp_miss_btb", bus.o_upd_btb_vld, 1);
        checkOutput("s5_jmp_miss_redirect", bus.o_redirect, 0);
        applyStimulus(1, 32'hFFFF_FFFC, 32'h0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("s5_wrap_redirect", bus.o_redirect, 0);
        checkOutput("s5_wrap_pht_pc", bus.o_upd_pht_pc, 32'hFFFF_FFFC);

        // Reset in the middle of activity kills pulses and discards the queue.
        applyStimulus(1, 32'h40, 32'h44, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h50, 32'h54, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        rst_n = 0;
        #1;
        checkOutput("s6_rst_pht", bus.o_upd_pht_vld, 0);
        checkOutput("s6_rst_err", bus.o_err, 0);
        checkOutput("s6_rst_rdy", bus.o_pred_rdy, 0);
        @(posedge clk); #2 rst_n = 1;
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("s6_discarded_err", bus.o_err, 1);
        checkOutput("s6_discarded_pht", bus.o_upd_pht_vld, 0);

        // Seventeen mispredicting branches saturate both counters.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1, 32'h1000, 32'h1004, 1, 0, 0, 0, 0, 0, 0);
            applyStimulus(0, 0, 0, 0, 1, 1, 0, 1, 32'h2000, 0);
        end
        @(negedge clk);
        checkOutput("s7_br_cnt", bus.o_perf_br_cnt, 64'(SAT_EXP));
        checkOutput("s7_mis_cnt", bus.o_perf_mispred_cnt, 64'(SAT_EXP));
        checkOutput("s7_redirect_pc", bus.o_redirect_pc, 32'h2000);

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
